// File: rtl/iq_freelist_pkg.sv
// Shared types and helpers for the issue-queue free-list controller.
// Default widths mirror the common configuration (32-entry IQ, 4 dispatch lanes, 4 free lanes).
package iq_freelist_pkg;

    localparam int IQ_DEPTH  = 32;
    localparam int IQ_INDEX  = 5;
    localparam int IQ_DISP_W = 4;
    localparam int IQ_FREE_W = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef logic [IQ_INDEX-1:0] iq_idx_t;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/iq_free_compact.sv
// Prefix-sum compactor: packs the sparse set freeing lanes onto the lowest write ports at the tail.
module iq_free_compact
    import iq_freelist_pkg::*;
#(
    parameter int FREE_W = IQ_FREE_W,
    parameter int INDEX  = IQ_INDEX
) (
    input  logic [INDEX-1:0]             tail_i,
    input  logic [FREE_W-1:0]            valid_i,
    input  logic [FREE_W-1:0][INDEX-1:0] idx_i,
    output logic [FREE_W-1:0][INDEX-1:0] wr_addr_o,
    output logic [FREE_W-1:0][INDEX-1:0] wr_data_o,
    output logic [FREE_W-1:0]            we_o,
    output logic [INDEX:0]               cnt_o
);

    logic [INDEX:0] pos;

    always_comb begin
        wr_addr_o = '0;
        wr_data_o = '0;
        we_o      = '0;
        pos       = '0;
        for (int k = 0; k < FREE_W; k++) begin
            if (valid_i[k]) begin
                // pos is the number of valid lanes below k, i.e. this lane's write port
                for (int j = 0; j < FREE_W; j++) begin
                    if (pos == (INDEX+1)'(j)) begin
                        wr_addr_o[j] = tail_i + INDEX'(j);
                        wr_data_o[j] = idx_i[k];
                        we_o[j]      = 1'b1;
                    end
                end
                pos = pos + (INDEX+1)'(1);
            end
        end
        cnt_o = pos;
    end

endmodule

// File: rtl/iq_freelist_ctrl.sv
// Issue-queue free-list pointer/occupancy controller with RAM[i]=i (re)initialisation.
// Optional IQ_FREELIST_ERR_EN adds a sticky err_o for illegal free traffic.
module iq_freelist_ctrl
    import iq_freelist_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int INDEX  = IQ_INDEX,
    parameter int DISP_W = IQ_DISP_W,
    parameter int FREE_W = IQ_FREE_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic [DISP_W-1:0]            dispReq_i,
    input  logic                         backendStall_i,
    output logic                         stall_o,
    output logic [DISP_W-1:0][INDEX-1:0] allocIdx_o,
    input  logic [FREE_W-1:0]            freeValid_i,
    input  logic [FREE_W-1:0][INDEX-1:0] freeIdx_i,
    output logic [DISP_W-1:0][INDEX-1:0] rdAddr_o,
    input  logic [DISP_W-1:0][INDEX-1:0] rdData_i,
    output logic [FREE_W-1:0][INDEX-1:0] wrAddr_o,
    output logic [FREE_W-1:0][INDEX-1:0] wrData_o,
    output logic [FREE_W-1:0]            we_o,
    output logic [INDEX:0]               freeCnt_o,
    output logic                         ready_o,
`ifdef IQ_FREELIST_ERR_EN
    output logic                         err_o,
`endif
    output state_e                       dbg_state_o
);

    state_e             state_q, state_d;
    logic [INDEX-1:0]   init_cnt_q, init_cnt_d;
    logic [INDEX-1:0]   head_q, head_d;
    logic [INDEX-1:0]   tail_q, tail_d;
    logic [INDEX:0]     free_cnt_q, free_cnt_d;
    logic [INDEX:0]     n;
    logic [INDEX:0]     m;
    logic               fire;
    logic [FREE_W-1:0][INDEX-1:0] cmp_addr, cmp_data;
    logic [FREE_W-1:0]            cmp_we;

    assign n = (INDEX+1)'(popcount(32'(dispReq_i)));

    iq_free_compact #(.FREE_W(FREE_W), .INDEX(INDEX)) u_compact (
        .tail_i    (tail_q),
        .valid_i   (freeValid_i),
        .idx_i     (freeIdx_i),
        .wr_addr_o (cmp_addr),
        .wr_data_o (cmp_data),
        .we_o      (cmp_we),
        .cnt_o     (m)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;
        free_cnt_d = free_cnt_q;
        stall_o    = 1'b1;
        ready_o    = 1'b0;
        fire       = 1'b0;
        we_o       = '0;
        wrAddr_o   = '0;
        wrData_o   = '0;
        for (int i = 0; i < DISP_W; i++) begin
            rdAddr_o[i]   = head_q + INDEX'(i);
            allocIdx_o[i] = rdData_i[i];
        end
        if (flush_i) begin
            state_d    = INIT;
            init_cnt_d = '0;
            head_d     = '0;
            tail_d     = '0;
            free_cnt_d = '0;
        end else begin
            case (state_q)
                INIT: begin
                    we_o = '1;
                    for (int k = 0; k < FREE_W; k++) begin
                        wrAddr_o[k] = init_cnt_q + INDEX'(k);
                        wrData_o[k] = init_cnt_q + INDEX'(k);
                    end
                    init_cnt_d = init_cnt_q + INDEX'(FREE_W);
                    if (init_cnt_q == INDEX'(DEPTH - FREE_W)) begin
                        state_d    = RUN;
                        init_cnt_d = '0;
                        head_d     = '0;
                        tail_d     = '0;
                        free_cnt_d = (INDEX+1)'(DEPTH);
                    end
                end
                RUN: begin
                    ready_o = 1'b1;
                    // Registered count only: this cycle's frees cannot cover this cycle's demand
                    stall_o = (n > free_cnt_q);
                    fire    = (n != '0) && !stall_o && !backendStall_i;
                    we_o     = cmp_we;
                    wrAddr_o = cmp_addr;
                    wrData_o = cmp_data;
                    if (fire) begin
                        head_d = head_q + n[INDEX-1:0];
                    end
                    tail_d     = tail_q + m[INDEX-1:0];
                    free_cnt_d = free_cnt_q - (fire ? n : '0) + m;
                end
                default: state_d = INIT;
            endcase
        end
        if (reset) begin
            stall_o = 1'b1;
            ready_o = 1'b0;
            we_o    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            free_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    assign freeCnt_o   = free_cnt_q;
    assign dbg_state_o = state_q;

`ifdef IQ_FREELIST_ERR_EN
    logic err_q, err_d;
    logic free_full, over_cnt, dup_idx, chk_en;

    always_comb begin
        chk_en    = (state_q == RUN) && !flush_i && !reset;
        free_full = (free_cnt_q == (INDEX+1)'(DEPTH)) && (m != '0);
        over_cnt  = (free_cnt_d > (INDEX+1)'(DEPTH));
        dup_idx   = 1'b0;
        for (int a = 0; a < FREE_W; a++) begin
            for (int b = a + 1; b < FREE_W; b++) begin
                if (freeValid_i[a] && freeValid_i[b] && (freeIdx_i[a] == freeIdx_i[b])) begin
                    dup_idx = 1'b1;
                end
            end
        end
        err_d = flush_i ? 1'b0 : (err_q | (chk_en && (free_full || over_cnt || dup_idx)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
        if (chk_en) begin
            assert (!free_full);
            assert (!over_cnt);
            assert (!dup_idx);
        end
    end

    assign err_o = err_q;
`endif

endmodule
